// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Brief    : Shared types and constants for the RV32I program counter unit.
// Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

  // Program counter control states
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  // Branch condition codes, matching the comparator flag order (bit0 = EQ)
  localparam logic [2:0] BR_EQ  = 3'd0;
  localparam logic [2:0] BR_NE  = 3'd1;
  localparam logic [2:0] BR_LT  = 3'd2;
  localparam logic [2:0] BR_LTU = 3'd3;
  localparam logic [2:0] BR_GE  = 3'd4;
  localparam logic [2:0] BR_GEU = 3'd5;

  // Sequential increments for 16-bit and 32-bit instructions
  localparam int INC_16 = 2;
  localparam int INC_32 = 4;

endpackage
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// ============================================================================
// Module   : pc_target_calc
// Brief    : Combinational branch decision, target address and alignment
//            fault detection for the program counter unit.
// Revision : 1.0 - initial release
// ============================================================================
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int dataW    = 32,
  parameter bit SupportC = 1'b1
) (
  input  logic             i_eq,
  input  logic             i_ne,
  input  logic             i_lt,
  input  logic             i_ltu,
  input  logic             i_ge,
  input  logic             i_geu,
  input  logic             i_testBranch,
  input  logic             i_alwaysBranch,
  input  logic             i_absoluteBranch,
  input  logic [2:0]       i_branchType,
  input  logic [dataW-1:0] i_branchAddr,
  input  logic [dataW-1:0] i_progAddr,
  output logic             o_taken,
  output logic [dataW-1:0] o_target,
  output logic             o_misaligned
);

  logic             w_cond;
  logic [dataW-1:0] w_rawTarget;

  // Select the comparator flag named by the branch code; codes 6 and 7 never take
  always_comb begin
    w_cond = 1'b0;
    case (i_branchType)
      BR_EQ:   w_cond = i_eq;
      BR_NE:   w_cond = i_ne;
      BR_LT:   w_cond = i_lt;
      BR_LTU:  w_cond = i_ltu;
      BR_GE:   w_cond = i_ge;
      BR_GEU:  w_cond = i_geu;
      default: w_cond = 1'b0;
    endcase
  end

  assign o_taken = (i_testBranch && w_cond) || i_alwaysBranch;

  // Relative targets wrap silently modulo 2^dataW; bit0 is always cleared
  assign w_rawTarget = i_absoluteBranch ? i_branchAddr : (i_progAddr + i_branchAddr);
  assign o_target    = {w_rawTarget[dataW-1:1], 1'b0};

  // Without compressed support every target must be word aligned
  assign o_misaligned = o_taken && !SupportC && w_rawTarget[1];

endmodule
`default_nettype wire

// File: rtl/pc_unit_r32ic.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit_r32ic
// Brief    : RV32I program counter with optional compressed increments,
//            misaligned-target trapping, saved exception PC, trap return
//            and a run/trap/halt control state machine.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit_r32ic
  import pc_pkg::*;
#(
  parameter int               dataW       = 32,
  parameter logic [dataW-1:0] ResetVector = '0,
  parameter logic [dataW-1:0] TrapVector  = 'h100,
  parameter bit               SupportC    = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             EQ,
  input  logic             NE,
  input  logic             LT,
  input  logic             LTU,
  input  logic             GE,
  input  logic             GEU,
  input  logic             TestBranch,
  input  logic             AlwaysBranch,
  input  logic             AbsoluteBranch,
  input  logic             IsCompressed,
  input  logic             InsCacheStall,
  input  logic             TrapReturn,
  input  logic [2:0]       BranchType,
  input  logic [dataW-1:0] BranchAddr,
  output logic [dataW-1:0] ProgAddr,
  output logic [dataW-1:0] LinkAddr,
  output logic [dataW-1:0] EpcAddr,
  output logic             TrapTaken,
  output logic             InTrap,
  output logic             Halted
);

  localparam logic [1:0] c_ST_RUN  = RUN;
  localparam logic [1:0] c_ST_TRAP = TRAP;
  localparam logic [1:0] c_ST_HALT = HALT;

  logic [dataW-1:0] r_progAddr;
  logic [dataW-1:0] r_epcAddr;
  logic             r_trapTaken;
  logic [1:0]       r_state;

  logic [dataW-1:0] w_inc;
  logic [dataW-1:0] w_target;
  logic             w_taken;
  logic             w_misaligned;

  pc_target_calc #(
    .dataW    (dataW),
    .SupportC (SupportC)
  ) u_targetCalc (
    .i_eq             (EQ),
    .i_ne             (NE),
    .i_lt             (LT),
    .i_ltu            (LTU),
    .i_ge             (GE),
    .i_geu            (GEU),
    .i_testBranch     (TestBranch),
    .i_alwaysBranch   (AlwaysBranch),
    .i_absoluteBranch (AbsoluteBranch),
    .i_branchType     (BranchType),
    .i_branchAddr     (BranchAddr),
    .i_progAddr       (r_progAddr),
    .o_taken          (w_taken),
    .o_target         (w_target),
    .o_misaligned     (w_misaligned)
  );

  // IsCompressed only matters when 16-bit instructions are supported
  assign w_inc    = (SupportC && IsCompressed) ? dataW'(INC_16) : dataW'(INC_32);
  assign LinkAddr = r_progAddr + w_inc;

  // PC, exception PC, fault pulse and control state update in priority order
  always_ff @(posedge clock) begin
    if (reset) begin
      r_progAddr  <= ResetVector;
      r_epcAddr   <= '0;
      r_trapTaken <= 1'b0;
      r_state     <= c_ST_RUN;
    end else if (InsCacheStall) begin
      r_trapTaken <= 1'b0;
    end else begin
      r_trapTaken <= 1'b0;
      case (r_state)
        c_ST_RUN: begin
          if (w_misaligned) begin
            r_epcAddr   <= r_progAddr;
            r_progAddr  <= TrapVector;
            r_trapTaken <= 1'b1;
            r_state     <= c_ST_TRAP;
          end else if (w_taken) begin
            r_progAddr <= w_target;
          end else begin
            r_progAddr <= LinkAddr;
          end
        end
        c_ST_TRAP: begin
          if (TrapReturn) begin
            r_progAddr <= r_epcAddr;
            r_state    <= c_ST_RUN;
          end else if (w_misaligned) begin
            r_state <= c_ST_HALT;
          end else if (w_taken) begin
            r_progAddr <= w_target;
          end else begin
            r_progAddr <= LinkAddr;
          end
        end
        default: begin
          // Halted: everything frozen until reset
        end
      endcase
    end
  end

  assign ProgAddr  = r_progAddr;
  assign EpcAddr   = r_epcAddr;
  assign TrapTaken = r_trapTaken;
  assign InTrap    = (r_state == c_ST_TRAP);
  assign Halted    = (r_state == c_ST_HALT);

endmodule
`default_nettype wire
